// File: rtl/riscv_pkg.sv
// Shared types for the data-memory port: read-owner tracking for the
// single-port block RAM and the width of the secondary wait counter.
package riscv_pkg;

    localparam int WAIT_W = 4;

    // Who owns the read data returned by the RAM in the following cycle.
    typedef enum logic [1:0] {
        OWN_NONE   = 2'd0,
        OWN_CPU    = 2'd1,
        OWN_SEC_RD = 2'd2
    } mem_owner_e;

endpackage

// File: rtl/data_mem_arbiter.sv
// Data-memory arbiter: the CPU pipeline and a secondary (debug/DMA) master
// share one single-port block RAM. The CPU normally wins. A waiting secondary
// request is forced through after MAX_WAIT consecutive losing cycles, and the
// CPU is stalled for that one cycle.
//
// Secondary handshake: a request transfers in a cycle where i_sec_valid and
// o_sec_ready are both high. o_sec_ready is combinational and depends on the
// current inputs. Dropping i_sec_valid before ready counts as a withdrawal:
// no access is made. A read returns o_sec_rvalid for exactly one cycle, one
// cycle after the transfer. Writes produce no response.
module data_mem_arbiter
    import riscv_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [XLEN-1:0]   i_cpu_addr,
    input  logic [XLEN-1:0]   i_cpu_wdata,
    input  logic [XLEN/8-1:0] i_cpu_byte_en,
    output logic              o_cpu_stall,
    input  logic              i_sec_valid,
    input  logic              i_sec_we,
    input  logic [XLEN-1:0]   i_sec_addr,
    input  logic [XLEN-1:0]   i_sec_wdata,
    input  logic [XLEN/8-1:0] i_sec_byte_en,
    output logic              o_sec_ready,
    output logic              o_sec_rvalid,
    output logic [XLEN-1:0]   o_sec_rdata,
    output logic              o_mem_en,
    output logic [XLEN-1:0]   o_mem_addr,
    output logic [XLEN-1:0]   o_mem_wdata,
    output logic [XLEN/8-1:0] o_mem_byte_en,
    input  logic [XLEN-1:0]   i_mem_rdata,
    output mem_owner_e        o_dbg_rd_owner,
    output logic [WAIT_W-1:0] o_dbg_wait_cnt
);

    localparam int                BE_W     = XLEN / 8;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_cnt_next;
    mem_owner_e        rd_owner;
    mem_owner_e        rd_owner_next;
    logic              sec_grant;
    logic              cpu_grant;
    logic [XLEN-1:0]   sec_rdata_q;

    // Grant decision: secondary wins when the CPU is idle or it has waited long enough.
    always_comb begin
        sec_grant = 1'b0;
        cpu_grant = 1'b0;
        if (!i_rst) begin
            sec_grant = i_sec_valid && (!i_cpu_req || (wait_cnt == WAIT_MAX));
            cpu_grant = i_cpu_req && !sec_grant;
        end
    end

    // RAM request mux; byte strobes only on stores so reads never modify memory.
    always_comb begin
        o_mem_en      = 1'b0;
        o_mem_addr    = '0;
        o_mem_wdata   = '0;
        o_mem_byte_en = '0;
        if (sec_grant) begin
            o_mem_en      = 1'b1;
            o_mem_addr    = i_sec_addr;
            o_mem_wdata   = i_sec_wdata;
            o_mem_byte_en = i_sec_we ? i_sec_byte_en : {BE_W{1'b0}};
        end else if (cpu_grant) begin
            o_mem_en      = 1'b1;
            o_mem_addr    = i_cpu_addr;
            o_mem_wdata   = i_cpu_wdata;
            o_mem_byte_en = i_cpu_we ? i_cpu_byte_en : {BE_W{1'b0}};
        end
    end

    // Next-state logic for the wait counter and the read-owner record.
    always_comb begin
        wait_cnt_next = wait_cnt;
        rd_owner_next = OWN_NONE;
        if (i_rst) begin
            wait_cnt_next = '0;
            rd_owner_next = OWN_NONE;
        end else begin
            if (sec_grant || !i_sec_valid) begin
                wait_cnt_next = '0;
            end else if (wait_cnt < WAIT_MAX) begin
                wait_cnt_next = wait_cnt + 1'b1;
            end
            if (sec_grant && !i_sec_we) begin
                rd_owner_next = OWN_SEC_RD;
            end else if (cpu_grant) begin
                rd_owner_next = OWN_CPU;
            end
        end
    end

    // Control state register.
    always_ff @(posedge i_clk) begin
        wait_cnt <= wait_cnt_next;
        rd_owner <= rd_owner_next;
    end

    // Hold the last secondary read word so o_sec_rdata stays stable between responses.
    always_ff @(posedge i_clk) begin
        if (o_sec_rvalid) begin
            sec_rdata_q <= i_mem_rdata;
        end
    end

    // A response still pending when reset arrives is dropped.
    assign o_sec_rvalid   = (rd_owner == OWN_SEC_RD) && !i_rst;
    assign o_sec_rdata    = o_sec_rvalid ? i_mem_rdata : sec_rdata_q;
    assign o_sec_ready    = sec_grant;
    assign o_cpu_stall    = i_cpu_req && sec_grant;
    assign o_dbg_rd_owner = rd_owner;
    assign o_dbg_wait_cnt = wait_cnt;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: a behavioural block RAM, a reference model of
// the grant rule and memory contents, and a queue of expected secondary read
// data checked against each response.
module tb_data_mem_arbiter;
    import riscv_pkg::*;

    localparam int XLEN     = 32;
    localparam int MAX_WAIT = 4;

    typedef struct {
        logic        rst;
        logic        cpu_req;
        logic        cpu_we;
        logic [31:0] cpu_addr;
        logic [31:0] cpu_wdata;
        logic [3:0]  cpu_be;
        logic        sec_valid;
        logic        sec_we;
        logic [31:0] sec_addr;
        logic [31:0] sec_wdata;
        logic [3:0]  sec_be;
    } stim_t;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_cpu_req, i_cpu_we;
    logic [31:0] i_cpu_addr, i_cpu_wdata;
    logic [3:0]  i_cpu_byte_en;
    logic        o_cpu_stall;
    logic        i_sec_valid, i_sec_we;
    logic [31:0] i_sec_addr, i_sec_wdata;
    logic [3:0]  i_sec_byte_en;
    logic        o_sec_ready, o_sec_rvalid;
    logic [31:0] o_sec_rdata;
    logic        o_mem_en;
    logic [31:0] o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_byte_en;
    logic [31:0] i_mem_rdata;
    mem_owner_e  o_dbg_rd_owner;
    logic [3:0]  o_dbg_wait_cnt;

    data_mem_arbiter #(.XLEN(XLEN), .MAX_WAIT(MAX_WAIT)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_cpu_req(i_cpu_req), .i_cpu_we(i_cpu_we), .i_cpu_addr(i_cpu_addr),
        .i_cpu_wdata(i_cpu_wdata), .i_cpu_byte_en(i_cpu_byte_en), .o_cpu_stall(o_cpu_stall),
        .i_sec_valid(i_sec_valid), .i_sec_we(i_sec_we), .i_sec_addr(i_sec_addr),
        .i_sec_wdata(i_sec_wdata), .i_sec_byte_en(i_sec_byte_en), .o_sec_ready(o_sec_ready),
        .o_sec_rvalid(o_sec_rvalid), .o_sec_rdata(o_sec_rdata),
        .o_mem_en(o_mem_en), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
        .o_mem_byte_en(o_mem_byte_en), .i_mem_rdata(i_mem_rdata),
        .o_dbg_rd_owner(o_dbg_rd_owner), .o_dbg_wait_cnt(o_dbg_wait_cnt)
    );

    // ---------------- clock ----------------
    always #5 i_clk = ~i_clk;

    // ---------------- block RAM model (64 words, addr[7:2]) ----------------
    logic [31:0] ram     [0:63];
    logic [31:0] ref_mem [0:63];

    function automatic logic [31:0] init_word(input int i);
        return 32'h5A000000 ^ (32'(i) * 32'h00010203);
    endfunction

    always @(posedge i_clk) begin
        if (o_mem_en) begin
            i_mem_rdata <= ram[o_mem_addr[7:2]];
            for (int b = 0; b < 4; b++) begin
                if (o_mem_byte_en[b]) ram[o_mem_addr[7:2]][8*b +: 8] <= o_mem_wdata[8*b +: 8];
            end
        end
    end

    // ---------------- scoreboard state ----------------
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic        exp_rd_grant = 1'b0;
    logic        rd_prev = 1'b0;
    logic        mon_en = 1'b0;
    logic        have_resp = 1'b0;
    logic [31:0] last_rdata = '0;
    logic [3:0]  m_wait = '0;
    mem_owner_e  m_owner = OWN_NONE;
    logic        m_owner_known = 1'b0;
    logic        obs_ready, obs_stall;
    logic [3:0]  obs_wait;
    logic [31:0] obs_mem_rdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus, predict the arbiter, and check combinational outputs.
    task automatic drive(input stim_t s);
        logic        sg, cg;
        logic [31:0] a_exp, d_exp;
        logic [3:0]  be_exp;
        @(negedge i_clk);
        i_rst = s.rst;
        i_cpu_req = s.cpu_req; i_cpu_we = s.cpu_we; i_cpu_addr = s.cpu_addr;
        i_cpu_wdata = s.cpu_wdata; i_cpu_byte_en = s.cpu_be;
        i_sec_valid = s.sec_valid; i_sec_we = s.sec_we; i_sec_addr = s.sec_addr;
        i_sec_wdata = s.sec_wdata; i_sec_byte_en = s.sec_be;
        sg = !s.rst && s.sec_valid && (!s.cpu_req || m_wait == 4'(MAX_WAIT));
        cg = !s.rst && s.cpu_req && !sg;
        exp_rd_grant = sg && !s.sec_we;
        if (exp_rd_grant) exp_q.push_back(ref_mem[s.sec_addr[7:2]]);
        a_exp = '0; d_exp = '0; be_exp = '0;
        if (sg) begin
            a_exp = s.sec_addr; d_exp = s.sec_wdata; be_exp = s.sec_we ? s.sec_be : 4'b0;
        end else if (cg) begin
            a_exp = s.cpu_addr; d_exp = s.cpu_wdata; be_exp = s.cpu_we ? s.cpu_be : 4'b0;
        end
        #1;
        obs_ready = o_sec_ready; obs_stall = o_cpu_stall;
        obs_wait = o_dbg_wait_cnt; obs_mem_rdata = i_mem_rdata;
        check("mem_en", 32'(o_mem_en), 32'(sg || cg));
        check("sec_ready", 32'(o_sec_ready), 32'(sg));
        check("cpu_stall", 32'(o_cpu_stall), 32'(s.cpu_req && sg));
        check("mem_byte_en", 32'(o_mem_byte_en), 32'(be_exp));
        check("wait_cnt", 32'(o_dbg_wait_cnt), 32'(m_wait));
        if (m_owner_known) check("rd_owner", 32'(o_dbg_rd_owner), 32'(m_owner));
        if (sg || cg) begin
            check("mem_addr", o_mem_addr, a_exp);
            check("mem_wdata", o_mem_wdata, d_exp);
            for (int b = 0; b < 4; b++) begin
                if (be_exp[b]) ref_mem[a_exp[7:2]][8*b +: 8] = d_exp[8*b +: 8];
            end
        end
        if (s.rst || sg || !s.sec_valid) m_wait = '0;
        else if (m_wait < 4'(MAX_WAIT)) m_wait = m_wait + 4'd1;
        if (s.rst) m_owner = OWN_NONE;
        else if (sg && !s.sec_we) m_owner = OWN_SEC_RD;
        else if (cg) m_owner = OWN_CPU;
        else m_owner = OWN_NONE;
        if (s.rst) m_owner_known = 1'b1;
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    // Response monitor: rvalid must follow each predicted read grant unless reset intervened.
    initial begin
        logic        exp_rv;
        logic [31:0] w;
        forever begin
            @(negedge i_clk);
            #2;
            if (mon_en) begin
                exp_rv = rd_prev && !i_rst;
                check("sec_rvalid", 32'(o_sec_rvalid), 32'(exp_rv));
                if (rd_prev) begin
                    if (exp_q.size() == 0) begin
                        check("sb_underflow", 32'(exp_q.size()), 32'd1);
                    end else begin
                        w = exp_q.pop_front();
                        if (exp_rv) begin
                            check("sec_rdata", o_sec_rdata, w);
                            last_rdata = w;
                            have_resp = 1'b1;
                        end
                    end
                end else if (have_resp) begin
                    check("rdata_hold", o_sec_rdata, last_rdata);
                end
                rd_prev = exp_rd_grant;
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        stim_t       s;
        logic [31:0] w80;
        for (int i = 0; i < 64; i++) begin
            ram[i] = init_word(i);
            ref_mem[i] = init_word(i);
        end
        i_mem_rdata = '0;
        s = idle(); s.rst = 1'b1;
        i_rst = 1'b1; i_cpu_req = 0; i_cpu_we = 0; i_cpu_addr = '0; i_cpu_wdata = '0;
        i_cpu_byte_en = '0; i_sec_valid = 0; i_sec_we = 0; i_sec_addr = '0;
        i_sec_wdata = '0; i_sec_byte_en = '0;
        mon_en = 1'b1;

        // Reset with both requesters active: nothing may be granted.
        s.cpu_req = 1'b1; s.sec_valid = 1'b1;
        repeat (3) drive(s);
        drive(idle());
        check("reset_owner", 32'(o_dbg_rd_owner), 32'(OWN_NONE));

        // CPU idle, secondary read of 0x40.
        s = idle(); s.sec_valid = 1'b1; s.sec_addr = 32'h40;
        drive(s);
        check("idle_sec_ready", 32'(obs_ready), 32'd1);
        check("idle_no_stall", 32'(obs_stall), 32'd0);
        drive(idle());
        check("rd40_rvalid", 32'(o_sec_rvalid), 32'd1);
        check("rd40_data", o_sec_rdata, init_word(16));

        // Continuous CPU traffic with the secondary request held: grant every 5th cycle.
        for (int i = 0; i < 15; i++) begin
            s = idle(); s.cpu_req = 1'b1; s.cpu_addr = 32'(i * 4);
            s.sec_valid = 1'b1; s.sec_addr = 32'h44;
            drive(s);
            check("sec_every5", 32'(obs_ready), 32'(i % 5 == 4));
            check("stall_every5", 32'(obs_stall), 32'(i % 5 == 4));
        end

        // CPU read of 0x10 immediately before a forced secondary grant.
        for (int j = 0; j < 6; j++) begin
            s = idle(); s.cpu_req = 1'b1;
            s.cpu_addr = (j >= 3) ? 32'h10 : 32'(32'h20 + 4 * j);
            s.sec_valid = (j < 5); s.sec_addr = 32'h48;
            drive(s);
            if (j == 4) begin
                check("cpu_rd_under_stall", obs_mem_rdata, init_word(4));
                check("stall_onset", 32'(obs_stall), 32'd1);
            end
        end
        drive(idle());

        // Secondary partial write, then read back.
        s = idle(); s.sec_valid = 1'b1; s.sec_we = 1'b1; s.sec_addr = 32'h80;
        s.sec_wdata = 32'hDEADBEEF; s.sec_be = 4'b0011;
        drive(s);
        drive(idle());
        check("wr_no_rvalid", 32'(o_sec_rvalid), 32'd0);
        s = idle(); s.sec_valid = 1'b1; s.sec_addr = 32'h80;
        drive(s);
        drive(idle());
        w80 = init_word(32);
        check("byte_merge", o_sec_rdata, {w80[31:16], 16'hBEEF});

        // Reset arriving while a secondary read response is pending.
        s = idle(); s.sec_valid = 1'b1; s.sec_addr = 32'h4C;
        drive(s);
        s = idle(); s.rst = 1'b1; s.cpu_req = 1'b1; s.sec_valid = 1'b1;
        drive(s);
        check("rst_no_rvalid", 32'(o_sec_rvalid), 32'd0);
        drive(idle());
        check("post_rst_owner", 32'(o_dbg_rd_owner), 32'(OWN_NONE));
        check("post_rst_wait", 32'(obs_wait), 32'd0);

        // Withdrawal at wait_cnt == 3 restarts counting.
        for (int k = 0; k < 10; k++) begin
            s = idle(); s.cpu_req = 1'b1; s.cpu_addr = 32'h30;
            s.sec_valid = (k != 3); s.sec_addr = 32'h50;
            drive(s);
            if (k == 3) check("wait_at_withdraw", 32'(obs_wait), 32'd3);
            if (k == 4) check("wait_restart", 32'(obs_wait), 32'd0);
            if (k >= 4) check("grant_after_restart", 32'(obs_ready), 32'(k == 8));
        end

        // Random traffic.
        for (int r = 0; r < 300; r++) begin
            s.rst       = ($urandom_range(0, 49) == 0);
            s.cpu_req   = $urandom_range(0, 3) != 0;
            s.cpu_we    = $urandom_range(0, 1) == 1;
            s.cpu_addr  = 32'($urandom_range(0, 63)) << 2;
            s.cpu_wdata = $urandom;
            s.cpu_be    = 4'($urandom_range(0, 15));
            s.sec_valid = $urandom_range(0, 2) != 0;
            s.sec_we    = $urandom_range(0, 2) == 0;
            s.sec_addr  = 32'($urandom_range(0, 63)) << 2;
            s.sec_wdata = $urandom;
            s.sec_be    = 4'($urandom_range(0, 15));
            drive(s);
        end

        drive(idle());
        drive(idle());
        @(negedge i_clk);
        #3;
        mon_en = 1'b0;
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
